// File: rtl/core_pkg.sv
// Shared types and operator-decode helpers for the iterative multiply/divide unit.
package core_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_opcode_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic md_is_signed_a(md_opcode_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_is_signed_b(md_opcode_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_is_div(md_opcode_e op);
        return op[2];
    endfunction

    function automatic logic md_is_rem(md_opcode_e op);
        return (op == MD_REM) || (op == MD_REMU);
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Radix-2 iteration datapath: unsigned shift-add multiply and restoring divide
// sharing one {hi, lo} register pair, plus the step counter.
module md_iter_core
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_mag_a,
    input  logic [XLEN-1:0] i_mag_b,
    output logic [XLEN-1:0] o_next_hi,
    output logic [XLEN-1:0] o_next_lo,
    output logic            o_last
);

    localparam int CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_b;
    logic [CNT_W-1:0] r_cnt;

    logic [XLEN:0]    w_add;
    logic [XLEN:0]    w_shift;
    logic [XLEN-1:0]  w_sub;
    logic             w_fits;

    // Multiply: lo holds the multiplier and fills with product bits from the top.
    assign w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    // Divide: the partial remainder is always < divisor, so XLEN bits of the
    // difference are exact whenever the trial subtraction fits.
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_fits  = (w_shift >= {1'b0, r_b});
    assign w_sub   = w_shift[XLEN-1:0] - r_b;

    // NOTE: every output of this always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        if (i_is_div) begin
            o_next_hi = w_fits ? w_sub : w_shift[XLEN-1:0];
            o_next_lo = {r_lo[XLEN-2:0], w_fits};
        end else begin
            {o_next_hi, o_next_lo} = {w_add, r_lo[XLEN-1:1]};
        end
    end

    assign o_last = (r_cnt == CNT_W'(XLEN - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // NOTE: pure datapath registers carry no reset; they are always loaded before being read.
    always_ff @(posedge clock) begin
        if (i_load) begin
            r_hi <= '0;
            r_lo <= i_mag_a;
            r_b  <= i_mag_b;
        end else if (i_step) begin
            r_hi <= o_next_hi;
            r_lo <= o_next_lo;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M iterative multiply/divide unit: FSM, sign handling, handshake, result register.
// Define MDU_FAST_PATH_EN to finish divide-by-zero, signed overflow and zero-operand multiplies in one cycle.
module ex_muldiv_unit
    import core_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  md_valid_ip,
    output logic                  md_ready_op,
    input  logic [2:0]            md_operator_ip,
    input  logic [XLEN-1:0]       md_operand_a_ip,
    input  logic [XLEN-1:0]       md_operand_b_ip,
    input  logic [REG_ADDR_W-1:0] md_write_reg_addr_ip,
    input  logic                  flush_ip,
    output logic [XLEN-1:0]       md_result_op,
    output logic                  md_result_valid_op,
    output logic [REG_ADDR_W-1:0] md_write_reg_addr_op,
    input  logic                  md_result_ready_ip
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e             r_state;
    md_opcode_e            r_op;
    logic                  r_neg;
    logic [XLEN-1:0]       r_result;
    logic [REG_ADDR_W-1:0] r_rd;

    md_opcode_e            w_op;
    logic                  w_a_neg, w_b_neg, w_neg;
    logic [XLEN-1:0]       w_mag_a, w_mag_b;
    logic                  w_accept, w_fast, w_last;
    logic [XLEN-1:0]       w_fast_result;
    logic [XLEN-1:0]       w_next_hi, w_next_lo;
    logic [2*XLEN-1:0]     w_prod_s;
    logic [XLEN-1:0]       w_div_sel, w_div_s, w_final;

    assign w_op     = md_opcode_e'(md_operator_ip);
    assign w_a_neg  = md_is_signed_a(w_op) && md_operand_a_ip[XLEN-1];
    assign w_b_neg  = md_is_signed_b(w_op) && md_operand_b_ip[XLEN-1];
    assign w_mag_a  = w_a_neg ? -md_operand_a_ip : md_operand_a_ip;
    assign w_mag_b  = w_b_neg ? -md_operand_b_ip : md_operand_b_ip;
    assign w_accept = (r_state == MD_IDLE) && md_valid_ip && !flush_ip;

    // A zero divisor leaves the all-ones quotient unsigned; the remainder keeps the dividend's sign.
    always_comb begin
        if (md_is_rem(w_op))
            w_neg = w_a_neg;
        else if (md_is_div(w_op))
            w_neg = (w_a_neg ^ w_b_neg) && (md_operand_b_ip != '0);
        else
            w_neg = w_a_neg ^ w_b_neg;
    end

`ifdef MDU_FAST_PATH_EN
    always_comb begin
        w_fast        = 1'b0;
        w_fast_result = '0;
        if (md_is_div(w_op)) begin
            if (md_operand_b_ip == '0) begin
                w_fast        = 1'b1;
                w_fast_result = md_is_rem(w_op) ? md_operand_a_ip : '1;
            end else if (md_is_signed_a(w_op) && md_operand_a_ip == MIN_INT && md_operand_b_ip == '1) begin
                w_fast        = 1'b1;
                w_fast_result = md_is_rem(w_op) ? '0 : md_operand_a_ip;
            end
        end else if (md_operand_a_ip == '0 || md_operand_b_ip == '0) begin
            w_fast = 1'b1;
        end
    end
`else
    assign w_fast        = 1'b0;
    assign w_fast_result = '0;
`endif

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_accept && !w_fast),
        .i_step    ((r_state == MD_CALC) && !flush_ip),
        .i_is_div  (md_is_div(r_op)),
        .i_mag_a   (w_mag_a),
        .i_mag_b   (w_mag_b),
        .o_next_hi (w_next_hi),
        .o_next_lo (w_next_lo),
        .o_last    (w_last)
    );

    assign w_prod_s  = r_neg ? -{w_next_hi, w_next_lo} : {w_next_hi, w_next_lo};
    assign w_div_sel = md_is_rem(r_op) ? w_next_hi : w_next_lo;
    assign w_div_s   = r_neg ? -w_div_sel : w_div_sel;

    always_comb begin
        if (md_is_div(r_op))
            w_final = w_div_s;
        else if (r_op == MD_MUL)
            w_final = w_prod_s[XLEN-1:0];
        else
            w_final = w_prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= MD_IDLE;
            r_op     <= MD_MUL;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
        end else if (flush_ip) begin
            r_state <= MD_IDLE;
        end else begin
            case (r_state)
                MD_IDLE: if (md_valid_ip) begin
                    r_op  <= w_op;
                    r_rd  <= md_write_reg_addr_ip;
                    r_neg <= w_neg;
                    if (w_fast) begin
                        r_result <= w_fast_result;
                        r_state  <= MD_DONE;
                    end else begin
                        r_state <= MD_CALC;
                    end
                end
                MD_CALC: if (w_last) begin
                    r_result <= w_final;
                    r_state  <= MD_DONE;
                end
                MD_DONE: if (md_result_ready_ip) r_state <= MD_IDLE;
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign md_ready_op          = (r_state == MD_IDLE);
    assign md_result_valid_op   = (r_state == MD_DONE);
    assign md_result_op         = r_result;
    assign md_write_reg_addr_op = r_rd;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed table, hand-written corner sequences,
// and randomized operations against an arithmetic RV32M reference model.
module tb_ex_muldiv_unit;
    import core_pkg::*;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            md_valid_ip = 1'b0;
    logic            md_ready_op;
    logic [2:0]      md_operator_ip = '0;
    logic [XLEN-1:0] md_operand_a_ip = '0;
    logic [XLEN-1:0] md_operand_b_ip = '0;
    logic [RW-1:0]   md_write_reg_addr_ip = '0;
    logic            flush_ip = 1'b0;
    logic [XLEN-1:0] md_result_op;
    logic            md_result_valid_op;
    logic [RW-1:0]   md_write_reg_addr_op;
    logic            md_result_ready_ip = 1'b0;

    always #5 clock = ~clock;

    ex_muldiv_unit #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clock                (clock),
        .reset                (reset),
        .md_valid_ip          (md_valid_ip),
        .md_ready_op          (md_ready_op),
        .md_operator_ip       (md_operator_ip),
        .md_operand_a_ip      (md_operand_a_ip),
        .md_operand_b_ip      (md_operand_b_ip),
        .md_write_reg_addr_ip (md_write_reg_addr_ip),
        .flush_ip             (flush_ip),
        .md_result_op         (md_result_op),
        .md_result_valid_op   (md_result_valid_op),
        .md_write_reg_addr_op (md_write_reg_addr_op),
        .md_result_ready_ip   (md_result_ready_ip)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] pss, psu, puu;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'h0, b});
        pss = 64'(sa * sb);
        psu = 64'(sa * ub);
        puu = {32'h0, a} * {32'h0, b};
        ia  = int'(a);
        ib  = int'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: return pss[31:0];
            3'd1: return pss[63:32];
            3'd2: return psu[63:32];
            3'd3: return puu[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_FAST_PATH_EN
        if (op[2] && b == 0) return 0;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        if (!op[2] && (a == 0 || b == 0)) return 0;
`endif
        return XLEN;
    endfunction

    // Drives one request at a negedge; returns at the negedge after the acceptance edge.
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [RW-1:0] rd, input string tag);
        int guard = 0;
        while (!md_ready_op && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check({tag, " ready_before_launch"}, 64'(md_ready_op), 64'd1);
        md_valid_ip          = 1'b1;
        md_operator_ip       = op;
        md_operand_a_ip      = a;
        md_operand_b_ip      = b;
        md_write_reg_addr_ip = rd;
        @(negedge clock);
        md_valid_ip          = 1'b0;
        md_operand_a_ip      = $urandom;
        md_operand_b_ip      = $urandom;
        md_operator_ip       = 3'($urandom);
        md_write_reg_addr_ip = RW'($urandom);
        check({tag, " busy_after_accept"}, 64'(md_ready_op), 64'd0);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!md_result_valid_op && lat < 200) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic consume(input string tag);
        md_result_ready_ip = 1'b1;
        @(negedge clock);
        md_result_ready_ip = 1'b0;
        check({tag, " idle_after_consume"}, {62'd0, md_ready_op, md_result_valid_op}, 64'b10);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        int            lat;
        logic [RW-1:0] rd;
        rd = RW'($urandom);
        launch(op, a, b, rd, tag);
        wait_valid(lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_latency(op, a, b)));
        check({tag, " result"}, 64'(md_result_op), 64'(exp));
        check({tag, " rd"}, 64'(md_write_reg_addr_op), 64'(rd));
        consume(tag);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [5];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        int   lat, seen;
        logic [31:0] exp;

        vecs[0] = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3] = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        vecs[4] = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5] = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6] = '{3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF};
        vecs[7] = '{3'd7, 32'd100,        32'd0,         32'd100};
        vecs[8] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[9] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0};

        repeat (2) @(negedge clock);
        check("reset outputs", {md_result_op, 25'd0, md_write_reg_addr_op, md_ready_op, md_result_valid_op},
              {32'h0, 25'd0, 5'd0, 1'b1, 1'b0});
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // Backpressure: result and rd held while downstream stalls.
        launch(3'd0, 32'd1234, 32'd5678, 5'd17, "bp");
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp hold%0d", c),
                  {md_result_op, 27'(md_write_reg_addr_op), md_ready_op, md_result_valid_op},
                  {32'd7006652, 27'd17, 1'b0, 1'b1});
            @(negedge clock);
        end
        consume("bp");

        // Flush at counter 10: E1..E10 are counters 0..9, the flush lands on E11.
        launch(3'd4, 32'd1000, 32'd7, 5'd9, "flush");
        repeat (10) @(negedge clock);
        flush_ip = 1'b1;
        @(negedge clock);
        flush_ip = 1'b0;
        check("flush idle", {62'd0, md_ready_op, md_result_valid_op}, 64'b10);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (md_result_valid_op) seen++;
            @(negedge clock);
        end
        check("flush never valid", 64'(seen), 64'd0);
        do_op(3'd6, 32'd1000, 32'd7, 32'd6, "after_flush");

        // Flush held in IDLE blocks acceptance.
        flush_ip    = 1'b1;
        md_valid_ip = 1'b1;
        md_operator_ip = 3'd0; md_operand_a_ip = 32'd3; md_operand_b_ip = 32'd3;
        @(negedge clock);
        md_valid_ip = 1'b0;
        flush_ip    = 1'b0;
        check("flush blocks accept", 64'(md_ready_op), 64'd1);

        // Reset mid-CALC, after a completed op left a nonzero result and rd.
        do_op(3'd0, 32'd9, 32'd9, 32'd81, "pre_reset");
        launch(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd21, "rst_calc");
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("reset mid-calc", {md_result_op, 25'd0, md_write_reg_addr_op, md_ready_op, md_result_valid_op},
              {32'h0, 25'd0, 5'd0, 1'b1, 1'b0});

        // Reset in DONE.
        launch(3'd0, 32'd6, 32'd7, 5'd30, "rst_done");
        wait_valid(lat);
        check("rst_done result", 64'(md_result_op), 64'd42);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("reset in done", {md_result_op, 25'd0, md_write_reg_addr_op, md_ready_op, md_result_valid_op},
              {32'h0, 25'd0, 5'd0, 1'b1, 1'b0});

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op  = 3'($urandom_range(0, 7));
            a   = pick_operand();
            b   = pick_operand();
            exp = ref_md(op, a, b);
            do_op(op, a, b, exp, $sformatf("rnd%0d op%0d a=%h b=%h", i, op, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
